// File: rtl/lfsr_rng.sv
// lfsr_rng: XNOR Fibonacci LFSR with enable, seed load, lock-up guard
// and a ranged draw engine (req/valid) with rejection sampling.
//
// Ports:
//   clk_i           system clock, posedge
//   rst_ni          asynchronous reset, active low
//   en_i            free-run step enable (ignored while drawing)
//   load_i          seed load pulse (highest priority)
//   seed_i          seed captured on load_i
//   draw_req_i      request one value in [0,RANGE-1], honoured when idle
//   state_o         current LFSR state
//   draw_busy_o     high while a draw is in progress
//   draw_valid_o    one-cycle pulse, draw_value_o/draw_fallback_o valid
//   draw_value_o    drawn value, held until the next draw_valid_o
//   draw_fallback_o draw ran out of tries, value forced to 0
//   seed_fixed_o    one-cycle pulse, all-ones seed replaced by 0
module lfsr_rng #(
   parameter int unsigned      WIDTH     = 4,
   parameter logic [WIDTH-1:0] TAPS      = WIDTH'(3),
   parameter int unsigned      OUT_W     = 4,
   parameter int unsigned      RANGE     = 10,
   parameter int unsigned      MAX_TRIES = 8
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             en_i,
   input  logic             load_i,
   input  logic [WIDTH-1:0] seed_i,
   input  logic             draw_req_i,
   output logic [WIDTH-1:0] state_o,
   output logic             draw_busy_o,
   output logic             draw_valid_o,
   output logic [OUT_W-1:0] draw_value_o,
   output logic             draw_fallback_o,
   output logic             seed_fixed_o
);

   localparam int unsigned TW = $clog2(MAX_TRIES + 1);
   localparam logic [OUT_W:0] RANGE_C = (OUT_W + 1)'(RANGE);
   localparam logic [TW-1:0]  LAST_C  = TW'(MAX_TRIES - 1);

   typedef enum logic {
      IDLE,
      DRAW
   } fsm_e;

   fsm_e             fsm_q, fsm_d;
   logic [WIDTH-1:0] state_q, state_d;
   logic [TW-1:0]    tries_q, tries_d;
   logic             busy_q, busy_d;
   logic             valid_q, valid_d;
   logic [OUT_W-1:0] value_q, value_d;
   logic             fb_q, fb_d;
   logic             fixed_q, fixed_d;

   logic [WIDTH-1:0] step;
   logic [OUT_W-1:0] cand;
   logic             cand_ok;
   logic             last_try;

   // XNOR feedback: all-ones is the lock-up state, zero is legal
   assign step     = {~^(state_q & TAPS), state_q[WIDTH-1:1]};
   assign cand     = state_q[OUT_W-1:0];
   assign cand_ok  = {1'b0, cand} < RANGE_C;
   assign last_try = (tries_q == LAST_C);

   always_comb begin
      fsm_d   = fsm_q;
      state_d = state_q;
      tries_d = tries_q;
      busy_d  = busy_q;
      valid_d = 1'b0;
      value_d = value_q;
      fb_d    = fb_q;
      fixed_d = 1'b0;
      if (load_i) begin
         // load aborts any draw and drops a same-cycle request
         if (&seed_i) begin
            state_d = '0;
            fixed_d = 1'b1;
         end else begin
            state_d = seed_i;
         end
         fsm_d   = IDLE;
         busy_d  = 1'b0;
         tries_d = '0;
      end else if (fsm_q == DRAW) begin
         state_d = step;
         if (cand_ok) begin
            value_d = cand;
            fb_d    = 1'b0;
            valid_d = 1'b1;
            fsm_d   = IDLE;
            busy_d  = 1'b0;
            tries_d = '0;
         end else if (last_try) begin
            value_d = '0;
            fb_d    = 1'b1;
            valid_d = 1'b1;
            fsm_d   = IDLE;
            busy_d  = 1'b0;
            tries_d = '0;
         end else begin
            tries_d = tries_q + TW'(1);
         end
      end else begin
         if (en_i) begin
            state_d = step;
         end
         if (draw_req_i) begin
            fsm_d   = DRAW;
            busy_d  = 1'b1;
            tries_d = '0;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         fsm_q   <= IDLE;
         state_q <= '0;
         tries_q <= '0;
         busy_q  <= 1'b0;
         valid_q <= 1'b0;
         value_q <= '0;
         fb_q    <= 1'b0;
         fixed_q <= 1'b0;
      end else begin
         fsm_q   <= fsm_d;
         state_q <= state_d;
         tries_q <= tries_d;
         busy_q  <= busy_d;
         valid_q <= valid_d;
         value_q <= value_d;
         fb_q    <= fb_d;
         fixed_q <= fixed_d;
      end
   end

   assign state_o         = state_q;
   assign draw_busy_o     = busy_q;
   assign draw_valid_o    = valid_q;
   assign draw_value_o    = value_q;
   assign draw_fallback_o = fb_q;
   assign seed_fixed_o    = fixed_q;

endmodule
